// File: rtl/word_memory_responder.sv
// word_memory_responder: little-endian 16-bit word read/write on a byte-wide
// memory, one byte per cycle (IDLE -> LO -> HI -> DONE), req/ready handshake.
module word_memory_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] Address,
    input  logic [15:0] WrData,
    output logic        Busy,
    output logic        Ready,
    output logic [15:0] RdData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   a_q, a_d;
    logic                    w_q, w_d;
    logic [15:0]             d_q, d_d;
    logic [15:0]             rd_data_q, rd_data_d;

    logic [7:0]              mem [0:DEPTH-1];
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [7:0]              mem_wdata;
    logic [7:0]              mem_rdata;

    // Address bits above the memory depth alias onto the same bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, Address[15:DEPTH_LOG2]};

    assign mem_rdata = mem[mem_addr];

    // Next-state, request latching and per-byte memory operation.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        w_d       = w_q;
        d_d       = d_q;
        rd_data_d = rd_data_q;
        mem_we    = 1'b0;
        mem_addr  = a_q;
        mem_wdata = d_q[7:0];
        case (state_q)
            IDLE: begin
                if (Req) begin
                    a_d     = Address[DEPTH_LOG2-1:0];
                    w_d     = Wr;
                    d_d     = WrData;
                    state_d = LO;
                end
            end
            LO: begin
                mem_addr  = a_q;
                mem_wdata = d_q[7:0];
                if (w_q) mem_we = 1'b1;
                else     rd_data_d[7:0] = mem_rdata;
                state_d = HI;
            end
            HI: begin
                // High byte wraps within the memory depth.
                mem_addr  = a_q + 1'b1;
                mem_wdata = d_q[15:8];
                if (w_q) mem_we = 1'b1;
                else     rd_data_d[15:8] = mem_rdata;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and data registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            w_q       <= 1'b0;
            d_q       <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            w_q       <= w_d;
            d_q       <= d_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Byte memory: contents are never cleared; no write in a reset cycle.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign Busy   = (state_q != IDLE);
    assign Ready  = (state_q == DONE);
    assign RdData = rd_data_q;

endmodule
